beeb_bus_responder: RTL

- 6502 bus target (responder) for the BBC Micro bus: decodes host cycles driven by a 6502-style initiator (Phi2, Addr, R/W, Data) and presents a two-register mailbox at BASE_ADDR.
- Host writes are pushed into a host-to-local (h2l) FIFO; host reads pop a local-to-host (l2h) FIFO.
- Local FPGA logic uses valid/ready streams on `clock`. Optional interrupt to the host on l2h data available.

---
 rtl/beeb_bus_responder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/beeb_bus_responder.sv
// beeb_bus_responder: BBC Micro 6502 bus target exposing a two-register
// mailbox at BASE_ADDR (reg0 = status/control, reg1 = data).
// Host writes to reg1 feed the h2l FIFO. Host reads of reg1 pop the l2h FIFO.
// Ports:
//   clock, Res_n            fast system clock, async active-low reset
//   PhiIn, Addr, R_W_n      host Phi2 (async), address, read(1)/write(0)
//   data_in                 host data bus input
//   data_out, data_oe       read data and output enable toward the host bus
//   irq_n                   active-low host interrupt (l2h data available)
//   h2l_data/valid/ready    local FWFT stream of bytes written by the host
//   l2h_data/valid/ready    local stream of bytes queued for the host

// Byte FIFO whose pointers carry one extra wrap bit so that full and empty
// can be told apart. Push and pop are guarded internally by full and empty.
module beeb_bus_fifo #(
  parameter int AW = 4
) (
  input  logic       clock,
  input  logic       Res_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);
  logic [7:0]  mem [2**AW];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;   // full is sampled before this cycle's pop
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge Res_n) begin
    if (!Res_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

module beeb_bus_responder #(
  parameter logic [15:0] BASE_ADDR = 16'hFCA0,
  parameter int          NSYNC     = 3,
  parameter int          FIFO_AW   = 4
) (
  input  logic        clock,
  input  logic        Res_n,
  input  logic        PhiIn,
  input  logic [15:0] Addr,
  input  logic        R_W_n,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        irq_n,
  output logic [7:0]  h2l_data,
  output logic        h2l_valid,
  input  logic        h2l_ready,
  input  logic [7:0]  l2h_data,
  input  logic        l2h_valid,
  output logic        l2h_ready
);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t           state;
  logic             reg_sel;
  logic             irq_en, ovf, unf;
  logic [NSYNC-1:0] sync;
  logic [7:0]       wr_byte;
  logic             rise, fall, match;
  logic             h2l_empty, h2l_full, l2h_empty, l2h_full;
  logic [7:0]       l2h_head, status;
  logic             h2l_push, l2h_pop;

  // Reset to all ones so releasing reset with PhiIn low looks like a fall,
  // which IDLE ignores, rather than a phantom rise.
  always_ff @(posedge clock or negedge Res_n) begin
    if (!Res_n) sync <= '1;
    else        sync <= {sync[NSYNC-2:0], PhiIn};
  end

  assign rise = ~sync[NSYNC-1] &  sync[NSYNC-2];
  assign fall =  sync[NSYNC-1] & ~sync[NSYNC-2];

  // Captured on the host's own Phi2 fall to meet 6502 write hold time; the
  // clock domain reads it only after the synchronised fall, when it is stable.
  always_ff @(negedge PhiIn or negedge Res_n) begin
    if (!Res_n) wr_byte <= 8'h00;
    else        wr_byte <= data_in;
  end

  assign match    = (Addr[15:1] == BASE_ADDR[15:1]);
  assign status   = {~l2h_empty, ~h2l_full, ovf, unf, 3'b000, irq_en};
  assign h2l_push = (state == WR) & fall & reg_sel;
  assign l2h_pop  = (state == RD) & fall & reg_sel;

  beeb_bus_fifo #(.AW(FIFO_AW)) u_h2l (
    .clock(clock), .Res_n(Res_n),
    .push(h2l_push), .push_data(wr_byte),
    .pop(h2l_valid & h2l_ready),
    .head(h2l_data), .empty(h2l_empty), .full(h2l_full)
  );

  beeb_bus_fifo #(.AW(FIFO_AW)) u_l2h (
    .clock(clock), .Res_n(Res_n),
    .push(l2h_valid & l2h_ready), .push_data(l2h_data),
    .pop(l2h_pop),
    .head(l2h_head), .empty(l2h_empty), .full(l2h_full)
  );

  assign h2l_valid = ~h2l_empty;
  assign l2h_ready = ~l2h_full;
  // Raw PhiIn so the bus driver lets go the instant Phi2 falls.
  assign data_oe   = (state == RD) & PhiIn;

  always_ff @(posedge clock or negedge Res_n) begin
    if (!Res_n) begin
      state    <= IDLE;
      reg_sel  <= 1'b0;
      irq_en   <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      data_out <= 8'hFF;
      irq_n    <= 1'b1;
    end else begin
      irq_n <= ~(irq_en & ~l2h_empty);
      if (rise) begin
        // A rise in RD/WR means the fall was missed: restart decode and drop
        // the pending pop/push.
        if (match) begin
          reg_sel <= Addr[0];
          if (R_W_n) begin
            state    <= RD;
            data_out <= Addr[0] ? (l2h_empty ? 8'hFF : l2h_head) : status;
          end else begin
            state <= WR;
          end
        end else begin
          state <= IDLE;
        end
      end else if (fall) begin
        case (state)
          RD: begin
            if (reg_sel && l2h_empty) unf <= 1'b1;
            state <= IDLE;
          end
          WR: begin
            if (!reg_sel) begin
              irq_en <= wr_byte[0];
              if (wr_byte[5]) ovf <= 1'b0;
              if (wr_byte[4]) unf <= 1'b0;
            end else if (h2l_full) begin
              ovf <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
